// File: rtl/muldiv_ctrl.sv
// Sequencer between the EX stage and an iterative divider: latches operands, stalls
// the pipe while dividing, writes HI/LO once, and enforces a one-cycle idle gap.
module muldiv_ctrl #(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall_ex,
    output logic        div_start,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sign_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    // Saturating increment so a very large MAX_CYCLES cannot wrap the counter.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (req_b != 32'd0) begin
                        a_d     = req_a;
                        b_d     = req_b;
                        sign_d  = req_signed;
                        cnt_d   = 8'd0;
                        state_d = RUN;
                    end else begin
                        // Divide-by-zero: MIPS-style result without touching the divider.
                        hi_d    = req_a;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = WB;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = GAP;
                end else if (div_done) begin
                    hi_d    = div_remainder;
                    lo_d    = div_quotient;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_inc;
                    if ({24'd0, cnt_inc} >= MAX_CYCLES) begin
                        err_d   = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            WB:      state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign div_start = (state_q == RUN);
    assign div_sign  = sign_q;
    assign div_a     = a_q;
    assign div_b     = b_q;
    // A flush landing on the write-back cycle kills the write.
    assign hilo_we   = (state_q == WB) && !flush;
    assign hi_wdata  = hi_q;
    assign lo_wdata  = lo_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign stall_ex  = ((state_q == IDLE) && req_valid && !flush) ||
                       (state_q == RUN) || (state_q == GAP);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a 34-cycle stub divider.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_signed, flush;
    logic [31:0] req_a, req_b;
    logic        stall_ex, div_start, div_sign, div_done;
    logic [31:0] div_a, div_b, div_quotient, div_remainder;
    logic        hilo_we, busy, err;
    logic [31:0] hi_wdata, lo_wdata;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MAX_CYCLES(40)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_signed(req_signed),
        .req_a(req_a), .req_b(req_b), .flush(flush), .stall_ex(stall_ex),
        .div_start(div_start), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .busy(busy), .err(err)
    );

    // Stub divider: done in the 34th consecutive cycle of div_start.
    logic       stub_en;
    logic [7:0] stub_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)           stub_cnt <= 8'd0;
        else if (div_start) stub_cnt <= stub_cnt + 8'd1;
        else                stub_cnt <= 8'd0;
    end
    assign div_done = stub_en && div_start && (stub_cnt == 8'd33);

    always_comb begin
        div_quotient  = 32'd0;
        div_remainder = 32'd0;
        if (div_b != 32'd0) begin
            if (div_sign) begin
                div_quotient  = $signed(div_a) / $signed(div_b);
                div_remainder = $signed(div_a) % $signed(div_b);
            end else begin
                div_quotient  = div_a / div_b;
                div_remainder = div_a % div_b;
            end
        end
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one request at a negedge and follow it through WB, GAP and back to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        logic ok;
        ok = 1'b1;
        req_valid = 1'b1; req_signed = v.sgn; req_a = v.a; req_b = v.b;
        #1;
        if (!stall_ex) ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!hilo_we && lat < 200) begin
            if (!stall_ex || !busy) ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (v.b == 32'd0 && lat != 1) ok = 1'b0;
        check({tag, " latency"}, lat, v.lat);
        check({tag, " hi"}, hi_wdata, v.hi);
        check({tag, " lo"}, lo_wdata, v.lo);
        check({tag, " stall during op / stall low in WB"}, {ok, stall_ex}, 2'b10);
        @(negedge clk);
        check({tag, " GAP {we,start,busy,stall}"}, {hilo_we, div_start, busy, stall_ex}, 4'b0011);
        @(negedge clk);
        check({tag, " back to IDLE busy"}, busy, 1'b0);
    endtask

    initial begin
        int runs, errs, wes, c, c1, c2, nwe;
        logic [31:0] hi1, lo1, hi2, lo2;
        vec_t v;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         35};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  35};
        vecs[2] = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1};
        vecs[3] = '{1'b0, 32'd64,         32'd8,          32'd0,          32'd8,          35};
        vecs[4] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC,  35};
        vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  35};
        vecs[6] = '{1'b1, 32'd0,          32'd0,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[7] = '{1'b0, 32'd9,          32'd3,          32'd0,          32'd3,          35};

        rst = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_a = 32'd0; req_b = 32'd0;
        flush = 1'b0; stub_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset {start,we,err,busy,stall}", {div_start, hilo_we, err, busy, stall_ex}, 5'b0);
        check("reset hi", hi_wdata, 32'd0);
        check("reset lo", lo_wdata, 32'd0);
        check("reset div_a", div_a, 32'd0);
        req_valid = 1'b1; req_b = 32'd3;
        #1;
        check("reset stall follows IDLE+req", stall_ex, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Flush at RUN cycle 10, then 9/3 still works.
        req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush RUN we", hilo_we, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        check("flush RUN -> GAP {start,busy}", {div_start, busy}, 2'b01);
        wes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wes += int'(hilo_we);
        end
        check("flush RUN no write", wes, 0);
        check("flush RUN idle", busy, 1'b0);
        run_vec(vecs[7], "post-flush 9/3");

        // Flush coinciding with div_done.
        req_valid = 1'b1; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        c = 0;
        while (!div_done && c < 100) begin @(negedge clk); c++; end
        check("done seen in RUN cycle 34", c + 1, 34);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush+done -> GAP {we,start,busy}", {hilo_we, div_start, busy}, 3'b001);
        @(negedge clk);

        // Flush during WB of divide-by-zero.
        req_valid = 1'b1; req_a = 32'd5; req_b = 32'd0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("flush WB we", hilo_we, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        check("flush WB -> GAP {start,busy,stall}", {div_start, busy, stall_ex}, 3'b011);
        @(negedge clk);

        // Flush with req_valid in IDLE: nothing accepted.
        req_valid = 1'b1; req_b = 32'd7; flush = 1'b1;
        #1;
        check("flush IDLE stall", stall_ex, 1'b0);
        @(negedge clk);
        check("flush IDLE not accepted", busy, 1'b0);
        req_valid = 1'b0; flush = 1'b0;

        // Watchdog with a divider that never finishes.
        stub_en = 1'b0;
        req_valid = 1'b1; req_a = 32'd1; req_b = 32'd1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        runs = 0; errs = 0; wes = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            runs += int'(div_start);
            errs += int'(err);
            wes  += int'(hilo_we);
            @(negedge clk);
        end
        check("watchdog RUN cycles", runs, 40);
        check("watchdog err pulses", errs, 1);
        check("watchdog no write", wes, 0);
        check("watchdog idle", {busy, err}, 2'b00);
        stub_en = 1'b1;

        // Back-to-back with req_valid held.
        req_valid = 1'b1; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); @(negedge clk);
        req_a = 32'd64; req_b = 32'd8;
        c = 0; nwe = 0; c1 = 0; c2 = 0;
        hi1 = 32'd0; lo1 = 32'd0; hi2 = 32'd0; lo2 = 32'd0;
        while (nwe < 2 && c < 300) begin
            if (hilo_we) begin
                if (nwe == 0) begin hi1 = hi_wdata; lo1 = lo_wdata; c1 = c; end
                else begin hi2 = hi_wdata; lo2 = lo_wdata; c2 = c; req_valid = 1'b0; end
                nwe++;
            end
            if (nwe < 2) begin @(negedge clk); c++; end
        end
        req_valid = 1'b0;
        check("b2b writes", nwe, 2);
        check("b2b lo1", lo1, 32'd14);
        check("b2b hi1", hi1, 32'd2);
        check("b2b lo2", lo2, 32'd8);
        check("b2b hi2", hi2, 32'd0);
        check("b2b spacing", c2 - c1, 37);
        repeat (2) @(negedge clk);

        // Reset mid-RUN.
        req_valid = 1'b1; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid-run reset {start,we,busy,stall,err}", {div_start, hilo_we, busy, stall_ex, err}, 5'b0);
        check("mid-run reset div_a", div_a, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wes = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            wes += int'(hilo_we) + int'(busy);
        end
        check("after reset no write/activity", wes, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
